// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared response codes, FSM states and 4 KB page helper for the AXI4 write master
package axi4_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_SHIFT = $clog2(PAGE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3
`ifdef AXI4_WM_BOUNDARY_CHECK_EN
        ,
        ST_ERR  = 3'd4
`endif
    } wm_state_e;

    // True when the last byte of the burst falls in a different 4 KB page than the first.
    function automatic logic crosses_page(input logic [31:0] start_addr,
                                          input logic [7:0]  len,
                                          input logic [31:0] beat_bytes);
        logic [31:0] last_addr;
        last_addr = start_addr + (32'(len) + 32'd1) * beat_bytes - 32'd1;
        return (start_addr >> PAGE_SHIFT) != (last_addr >> PAGE_SHIFT);
    endfunction

endpackage

// File: rtl/axi4_wm_fifo.sv
// rtl/axi4_wm_fifo.sv - synchronous write-data FIFO with full/empty flags
module axi4_wm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/axi4_write_master.sv
// rtl/axi4_write_master.sv - single-outstanding AXI4 INCR write master fed by a write-data FIFO
// Optional 4 KB boundary rejection is compiled in with AXI4_WM_BOUNDARY_CHECK_EN.
module axi4_write_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  busy
);

    localparam int         BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] BEAT_SIZE  = 3'($clog2(BEAT_BYTES));

    wm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  awvalid_q, awvalid_d;
    logic                  bready_q, bready_d;
    logic                  done_valid_q, done_valid_d;
    logic [1:0]            done_resp_q, done_resp_d;

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  w_valid, w_fire, w_last;

    assign cmd_ready = (state_q == ST_IDLE) && !ARESET;
    assign wd_ready  = !fifo_full && !ARESET;
    assign fifo_push = wd_valid && wd_ready;
    assign w_valid   = (state_q == ST_DATA) && !fifo_empty;
    assign w_fire    = w_valid && WREADY;
    assign w_last    = w_valid && (beat_cnt_q == awlen_q);

`ifdef AXI4_WM_BOUNDARY_CHECK_EN
    logic cmd_cross;
    logic err_pop;
    assign cmd_cross = crosses_page(32'(cmd_addr), cmd_len, 32'(BEAT_BYTES));
    // Rejected bursts still consume their data so the FIFO stays aligned with later commands.
    assign err_pop   = (state_q == ST_ERR) && !fifo_empty;
    assign fifo_pop  = w_fire || err_pop;
`else
    assign fifo_pop  = w_fire;
`endif

    axi4_wm_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (fifo_push),
        .push_data (wd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        beat_cnt_d   = beat_cnt_q;
        awvalid_d    = awvalid_q;
        bready_d     = bready_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    awaddr_d   = cmd_addr;
                    awlen_d    = cmd_len;
                    beat_cnt_d = '0;
`ifdef AXI4_WM_BOUNDARY_CHECK_EN
                    if (cmd_cross) begin
                        state_d = ST_ERR;
                    end else
`endif
                    begin
                        state_d   = ST_ADDR;
                        awvalid_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (AWREADY) begin
                    awvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == awlen_q) begin
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (BVALID) begin
                    bready_d     = 1'b0;
                    done_valid_d = 1'b1;
                    done_resp_d  = BRESP;
                    state_d      = ST_IDLE;
                end
            end
`ifdef AXI4_WM_BOUNDARY_CHECK_EN
            ST_ERR: begin
                if (err_pop) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == awlen_q) begin
                        done_valid_d = 1'b1;
                        done_resp_d  = SLVERR;
                        state_d      = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            beat_cnt_q   <= '0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= OKAY;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            beat_cnt_q   <= beat_cnt_d;
            awvalid_q    <= awvalid_d;
            bready_q     <= bready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end

    assign AWADDR     = awaddr_q;
    assign AWLEN      = awlen_q;
    assign AWSIZE     = BEAT_SIZE;
    assign AWVALID    = awvalid_q;
    assign WDATA      = w_valid ? fifo_head : '0;
    assign WVALID     = w_valid;
    assign WLAST      = w_last;
    assign BREADY     = bready_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/axi4_write_master.md
AXI4_WRITE_MASTER -- requirements
Module: axi4_write_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AXI byte address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning write-data FIFO entries (power of two).
REQ-004 SHALL have these ports; one clock, reset asynchronous and active-high:
  ACLK  in  1  clock, rising edge
  ARESET  in  1  asynchronous active-high reset
  cmd_valid / cmd_ready  in / out  1  burst command handshake
  cmd_addr  in  ADDR_WIDTH  burst start byte address
  cmd_len  in  8  beats minus one
  wd_valid / wd_ready  in / out  1  write-data push handshake
  wd_data  in  DATA_WIDTH  write-data beat
  AWADDR  out  ADDR_WIDTH;  AWLEN  out  8;  AWSIZE  out  3;  AWVALID  out  1;  AWREADY  in  1
  WDATA  out  DATA_WIDTH;  WLAST, WVALID  out  1;  WREADY  in  1
  BRESP  in  2;  BVALID  in  1;  BREADY  out  1
  done_valid  out  1  one-cycle pulse, burst complete
  done_resp  out  2  response for completed burst
  busy  out  1  FSM not IDLE

Function
REQ-005 FSM states: IDLE, ADDR, DATA, RESP (ERR only with REQ-020).
REQ-006 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, latch addr/len, go to ADDR.
REQ-007 ADDR: AWVALID=1, AWADDR/AWLEN held stable until AWREADY; on AWVALID&&AWREADY go to DATA next cycle.
REQ-008 AWSIZE SHALL be constant log2(DATA_WIDTH/8) (2 for 32-bit); burst type INCR implied.
REQ-009 W beats SHALL NOT start before AW handshake completes.
REQ-010 DATA: WVALID = FIFO not empty; WDATA = FIFO head; pop on WVALID&&WREADY.
REQ-011 8-bit beat counter SHALL reset to 0 on entering DATA and increment per W handshake; WLAST = WVALID && (count==latched len).
REQ-012 After the WLAST handshake, go to RESP; BREADY=1 only in RESP.
REQ-013 On BVALID&&BREADY: done_valid=1 for one cycle, done_resp=BRESP, return to IDLE.
REQ-014 WVALID, once asserted, SHALL NOT deassert before handshake (FIFO cannot empty without a pop).
REQ-015 FIFO: wd_ready = !full; push on wd_valid&&wd_ready in any state; simultaneous push and pop SHALL keep occupancy unchanged; push blocked when full even if a pop occurs that cycle.
REQ-016 len=0 SHALL produce a single beat with WLAST=1.
REQ-017 Back-to-back: a new command SHALL be accepted the cycle after done_valid (IDLE one cycle minimum).

Reset
REQ-018 On ARESET, regardless of state: FSM=IDLE, FIFO empty, counter=0; outputs AWVALID=WVALID=WLAST=BREADY=done_valid=busy=0, done_resp=0, AWADDR=AWLEN=WDATA=0, cmd_ready=0, wd_ready=0 during reset, both 1 on the first cycle after release.
REQ-019 Reset mid-burst SHALL abandon the burst with no done pulse.

Configuration
REQ-020 Macro AXI4_WM_BOUNDARY_CHECK_EN: when defined, a command whose last byte (cmd_addr + (cmd_len+1)*bytes - 1) lies in a different 4 KB page than cmd_addr SHALL skip AW/W/B, enter ERR, pop and discard cmd_len+1 FIFO beats as available, then pulse done_valid with done_resp=2'b10 (SLVERR); when undefined no check is made and every command is issued.

Structure
REQ-021 Package axi4_pkg SHALL hold: resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; FSM state enum; 4 KB page constant.
REQ-022 FIFO SHALL be a sub-module axi4_wm_fifo (sync FIFO, full/empty flags, same clock/reset).

Verification
REQ-023 Push 4 words 0xA0..0xA3, cmd addr=0x0010 len=3, AWREADY/WREADY always 1, BRESP=0 -> AWADDR=0x0010 AWLEN=3 AWSIZE=2, four beats, WLAST on 0xA3, done_resp=00.
REQ-024 len=0 with one word 0x55, WREADY held low 3 cycles -> WVALID/WDATA=0x55 stable, WLAST=1 on that beat, one handshake.
REQ-025 Push 16 words without a command -> wd_ready=0 after 16th; 17th not accepted; after a command with len=15 drains, all 16 issued in order.
REQ-026 Command len=7 with AWREADY delayed 5 cycles -> no WVALID before AW handshake; BRESP=2'b10 -> done_resp=10.
REQ-027 Assert ARESET at beat 2 of len=7 burst -> all outputs 0, no done pulse; next command runs normally.
REQ-028 With AXI4_WM_BOUNDARY_CHECK_EN, addr=0x0FF8 len=3 (4-byte beats) -> no AWVALID, 4 beats discarded, done_resp=10; without macro -> burst issued.
